// File: rtl/puzzle_setup_led.sv
// puzzle_setup_led: Avalon-MM LED output PIO with atomic set/clear addresses.
// Optional per-bit blink engine is built when PUZZLE_SETUP_LED_BLINK_EN is defined.
module puzzle_setup_led #(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wd;
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign readdata  = readdata_q;
  assign data_d = (wr && address == 3'd0) ? wd :
                  (wr && address == 3'd4) ? (data_q | wd) :
                  (wr && address == 3'd5) ? (data_q & ~wd) : data_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end
`ifdef PUZZLE_SETUP_LED_BLINK_EN
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d, prescale_q, prescale_d;
  logic                phase_q, phase_d;
  logic                period_wr, idle, tc;
  assign period_wr = wr && address == 3'd2;
  assign idle      = period_q == '0;
  assign tc        = prescale_q == period_q;
  // A period write wins over a coincident terminal count.
  assign mask_d     = (wr && address == 3'd1) ? wd : mask_q;
  assign period_d   = period_wr ? writedata[PERIOD_W-1:0] : period_q;
  assign prescale_d = (period_wr || idle || tc) ? '0 : prescale_q + PERIOD_W'(1);
  assign phase_d    = (period_wr || idle) ? 1'b0 : phase_q ^ tc;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      phase_q    <= phase_d;
    end
  end
  assign out_port   = data_q & ~(mask_q & {WIDTH{phase_q}});
  assign readdata_d = (address == 3'd0) ? 32'(data_q) :
                      (address == 3'd1) ? 32'(mask_q) :
                      (address == 3'd2) ? 32'(period_q) :
                      (address == 3'd3) ? {31'd0, phase_q} : '0;
`else
  assign out_port   = data_q;
  assign readdata_d = (address == 3'd0) ? 32'(data_q) : '0;
`endif
endmodule

// File: tb/tb_puzzle_setup_led.sv
// tb_puzzle_setup_led: directed bench for puzzle_setup_led; blink expectations
// follow whether PUZZLE_SETUP_LED_BLINK_EN is defined for the build.
module tb_puzzle_setup_led;
`ifdef PUZZLE_SETUP_LED_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [9:0]  out_port;
  int n = 0;
  int m = 0;

  puzzle_setup_led dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a;
    @(negedge clk);
    v = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    if (out_port !== 10'h000) begin $display("FAIL reset_out got %h want 000", out_port); m++; end
    n++;
    if (readdata !== 32'h0) begin $display("FAIL reset_rd got %h want 0", readdata); m++; end
    n++;
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(3'(a), v);
      if (v !== 32'h0) begin $display("FAIL reset_read%0d got %h want 0", a, v); m++; end
      n++;
    end
  endtask

  task automatic test_data;
    logic [31:0] v;
    wr(3'd0, 32'h155);
    if (out_port !== 10'h155) begin $display("FAIL data_out got %h want 155", out_port); m++; end
    n++;
    rd(3'd0, v);
    if (v !== 32'h155) begin $display("FAIL data_read got %h want 155", v); m++; end
    n++;
    wr(3'd0, 32'hFFFFF000);
    if (out_port !== 10'h000) begin $display("FAIL data_trunc got %h want 000", out_port); m++; end
    n++;
    wr(3'd0, 32'h00F);
    if (readdata !== 32'h0) begin $display("FAIL rdw_old got %h want 0", readdata); m++; end
    n++;
    if (out_port !== 10'h00F) begin $display("FAIL data_00f got %h want 00f", out_port); m++; end
    n++;
  endtask

  task automatic test_set_clear;
    logic [31:0] v;
    wr(3'd4, 32'h0F0);
    if (out_port !== 10'h0FF) begin $display("FAIL outset got %h want 0ff", out_port); m++; end
    n++;
    wr(3'd5, 32'h003);
    if (out_port !== 10'h0FC) begin $display("FAIL outclear got %h want 0fc", out_port); m++; end
    n++;
    wr(3'd6, 32'h3FF);
    if (out_port !== 10'h0FC) begin $display("FAIL reserved_wr got %h want 0fc", out_port); m++; end
    n++;
    wr(3'd3, 32'hFFFF_FFFF);
    if (out_port !== 10'h0FC) begin $display("FAIL status_wr got %h want 0fc", out_port); m++; end
    n++;
    for (int a = 4; a < 8; a++) begin
      rd(3'(a), v);
      if (v !== 32'h0) begin $display("FAIL read%0d got %h want 0", a, v); m++; end
      n++;
    end
    rd(3'd0, v);
    if (v !== 32'h0FC) begin $display("FAIL read0_after got %h want 0fc", v); m++; end
    n++;
  endtask

  task automatic test_blink;
    logic [31:0] v;
    logic [9:0]  e;
    logic        ph;
    logic        pph;
    wr(3'd0, 32'h3FF);
    wr(3'd1, 32'h001);
    wr(3'd2, 32'h003);
    address = 3'd3;
    pph = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ph = BL && ((i / 4) % 2 == 1);
      e = ph ? 10'h3FE : 10'h3FF;
      if (out_port !== e) begin $display("FAIL blink_out[%0d] got %h want %h", i, out_port, e); m++; end
      n++;
      if (i > 0) begin
        if (readdata !== {31'd0, pph}) begin $display("FAIL blink_phase[%0d] got %h want %h", i, readdata, pph); m++; end
        n++;
      end
      pph = ph;
      @(negedge clk);
    end
    rd(3'd1, v);
    if (v !== (BL ? 32'h1 : 32'h0)) begin $display("FAIL read_mask got %h want %h", v, BL ? 32'h1 : 32'h0); m++; end
    n++;
    rd(3'd2, v);
    if (v !== (BL ? 32'h3 : 32'h0)) begin $display("FAIL read_period got %h want %h", v, BL ? 32'h3 : 32'h0); m++; end
    n++;
  endtask

  task automatic test_period_boundary;
    logic [9:0] e;
    wr(3'd2, 32'h003);
    repeat (4) @(negedge clk);
    e = BL ? 10'h3FE : 10'h3FF;
    if (out_port !== e) begin $display("FAIL pre_phase1 got %h want %h", out_port, e); m++; end
    n++;
    wr(3'd2, 32'h005);
    for (int i = 0; i < 12; i++) begin
      e = (BL && i >= 6) ? 10'h3FE : 10'h3FF;
      if (out_port !== e) begin $display("FAIL period5[%0d] got %h want %h", i, out_port, e); m++; end
      n++;
      @(negedge clk);
    end
    wr(3'd2, 32'h000);
    for (int i = 0; i < 20; i++) begin
      if (out_port !== 10'h3FF) begin $display("FAIL period0[%0d] got %h want 3ff", i, out_port); m++; end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    logic [9:0]  e;
    wr(3'd2, 32'h001);
    @(negedge clk);
    @(negedge clk);
    e = BL ? 10'h3FE : 10'h3FF;
    if (out_port !== e) begin $display("FAIL pre_reset got %h want %h", out_port, e); m++; end
    n++;
    #2 reset_n = 1'b0;
    #1;
    if (out_port !== 10'h000) begin $display("FAIL async_out got %h want 000", out_port); m++; end
    n++;
    if (readdata !== 32'h0) begin $display("FAIL async_rd got %h want 0", readdata); m++; end
    n++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_port !== 10'h000) begin $display("FAIL post_reset[%0d] got %h want 000", i, out_port); m++; end
      n++;
      @(negedge clk);
    end
    for (int a = 0; a < 4; a++) begin
      rd(3'(a), v);
      if (v !== 32'h0) begin $display("FAIL post_read%0d got %h want 0", a, v); m++; end
      n++;
    end
  endtask

  initial begin
    test_reset;
    test_data;
    test_set_clear;
    test_blink;
    test_period_boundary;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n, m);
    $finish;
  end
endmodule
